uart_cmd_parser: RTL and testbench

//  Downstream consumer of the UART RX byte holder (CurrentData/DataAvailable/ClearData).

---
 rtl/uart_cmd_parser.sv | 149 ++++++++++++++
 tb/tb_uart_cmd_parser.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// Pops bytes from the UART RX holder and parses "$<op><hex...>CR" lines into commands.
// Byte processed the cycle after capture; CmdValid holds (and byte popping stalls) until CmdReady.
module uart_cmd_parser #(
    parameter int          ARG_DIGITS     = 8,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  START_CHAR     = 8'h24,
    parameter logic [7:0]  END_CHAR       = 8'h0D,
    localparam int         ARG_W          = 4 * ARG_DIGITS,
    localparam int         CNT_W          = $clog2(ARG_DIGITS + 1),
    localparam int         TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [7:0]       CurrentData,
    input  logic             DataAvailable,
    output logic             ClearData,
    output logic             CmdValid,
    input  logic             CmdReady,
    output logic [7:0]       CmdOp,
    output logic [ARG_W-1:0] CmdArg,
    output logic [CNT_W-1:0] CmdArgCount,
    output logic             CmdError,
    output logic [1:0]       ErrCode
);

    typedef enum logic [1:0] {IDLE, OPCODE, ARGS, HOLD} state_t;

    localparam logic [1:0] ERR_TIMEOUT  = 2'b00;
    localparam logic [1:0] ERR_OPCODE   = 2'b01;
    localparam logic [1:0] ERR_CHAR     = 2'b10;
    localparam logic [1:0] ERR_OVERFLOW = 2'b11;

    state_t          state, next_state;
    logic [7:0]      byte_q;
    logic [TO_W-1:0] timer;
    logic            capture;
    logic            running;
    logic            timeout;
    logic            err_set;
    logic [1:0]      err_code;
    logic            op_load;
    logic            arg_shift;
    logic            is_hex;
    logic [3:0]      nibble;
    logic            is_upper;

    // ClearData doubles as "byte_q holds a fresh byte to process this cycle".
    assign capture  = (state != HOLD) && DataAvailable && !ClearData;
    assign running  = (state == OPCODE) || (state == ARGS);
    assign timeout  = running && (timer == TO_W'(TIMEOUT_CYCLES - 1));
    assign is_upper = (byte_q >= 8'h41) && (byte_q <= 8'h5A);
    assign CmdValid = (state == HOLD);

    always_comb begin
        is_hex = 1'b0;
        nibble = 4'h0;
        if (byte_q >= 8'h30 && byte_q <= 8'h39) begin
            is_hex = 1'b1;
            nibble = byte_q[3:0];
        end else if ((byte_q >= 8'h41 && byte_q <= 8'h46) ||
                     (byte_q >= 8'h61 && byte_q <= 8'h66)) begin
            is_hex = 1'b1;
            nibble = byte_q[3:0] + 4'd9;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        err_set    = 1'b0;
        err_code   = ERR_TIMEOUT;
        op_load    = 1'b0;
        arg_shift  = 1'b0;
        if (timeout) begin
            err_set    = 1'b1;
            next_state = IDLE;
        end else if (state == HOLD) begin
            if (CmdReady) next_state = IDLE;
        end else if (ClearData) begin
            case (state)
                IDLE: begin
                    if (byte_q == START_CHAR) next_state = OPCODE;
                end
                OPCODE: begin
                    if (is_upper) begin
                        op_load    = 1'b1;
                        next_state = ARGS;
                    end else if (byte_q != START_CHAR) begin
                        err_set    = 1'b1;
                        err_code   = ERR_OPCODE;
                        next_state = IDLE;
                    end
                end
                ARGS: begin
                    if (is_hex) begin
                        if (CmdArgCount < CNT_W'(ARG_DIGITS)) begin
                            arg_shift = 1'b1;
                        end else begin
                            err_set    = 1'b1;
                            err_code   = ERR_OVERFLOW;
                            next_state = IDLE;
                        end
                    end else if (byte_q == END_CHAR) begin
                        next_state = HOLD;
                    end else begin
                        err_set    = 1'b1;
                        err_code   = ERR_CHAR;
                        next_state = (byte_q == START_CHAR) ? OPCODE : IDLE;
                    end
                end
                default: next_state = state;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            ClearData   <= 1'b0;
            byte_q      <= 8'h00;
            timer       <= '0;
            CmdOp       <= 8'h00;
            CmdArg      <= '0;
            CmdArgCount <= '0;
            CmdError    <= 1'b0;
            ErrCode     <= 2'b00;
        end else begin
            ClearData <= capture;
            if (capture) byte_q <= CurrentData;
            // Any state change restarts the idle window, as does each new byte.
            if (capture || next_state != state) timer <= '0;
            else if (running)                   timer <= timer + 1'b1;
            CmdError <= err_set;
            if (err_set) ErrCode <= err_code;
            if (op_load) begin
                CmdOp       <= byte_q;
                CmdArg      <= '0;
                CmdArgCount <= '0;
            end else if (arg_shift) begin
                CmdArg      <= {CmdArg[ARG_W-5:0], nibble};
                CmdArgCount <= CmdArgCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a byte-queue model of the RX holder.
module tb_uart_cmd_parser;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic [7:0]  CurrentData;
    logic        DataAvailable;
    logic        ClearData;
    logic        CmdValid;
    logic        CmdReady;
    logic [7:0]  CmdOp;
    logic [31:0] CmdArg;
    logic [3:0]  CmdArgCount;
    logic        CmdError;
    logic [1:0]  ErrCode;

    uart_cmd_parser #(.ARG_DIGITS(8), .TIMEOUT_CYCLES(100)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .CurrentData(CurrentData), .DataAvailable(DataAvailable), .ClearData(ClearData),
        .CmdValid(CmdValid), .CmdReady(CmdReady),
        .CmdOp(CmdOp), .CmdArg(CmdArg), .CmdArgCount(CmdArgCount),
        .CmdError(CmdError), .ErrCode(ErrCode)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] arg;
        logic [3:0]  n;
    } cmd_t;

    logic [7:0] rxq[$];
    cmd_t       cmdq[$];
    logic [1:0] errq[$];
    int         cyc = 0;
    int         clr_pulses = 0;
    int         hold_clr = 0;
    int         last_clr = 0;
    int         err_cyc = 0;
    logic       prev_valid = 1'b0;
    int         checks = 0;
    int         errors = 0;

    // RX holder model plus output monitor, both on the falling edge.
    always @(negedge Clock) begin
        cyc++;
        if (ClearData) begin
            clr_pulses++;
            last_clr = cyc;
            if (rxq.size() > 0) void'(rxq.pop_front());
        end
        if (ClearData && CmdValid) hold_clr++;
        if (CmdValid && !prev_valid) cmdq.push_back('{CmdOp, CmdArg, CmdArgCount});
        prev_valid = CmdValid;
        if (CmdError) begin
            errq.push_back(ErrCode);
            err_cyc = cyc;
        end
        if (rxq.size() > 0) begin
            DataAvailable = 1'b1;
            CurrentData   = rxq[0];
        end else begin
            DataAvailable = 1'b0;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) rxq.push_back(s[i]);
    endtask

    task automatic drain(input int extra);
        int n = 0;
        while (rxq.size() > 0 && n < 3000) begin
            @(negedge Clock);
            n++;
        end
        check_val("drain", rxq.size(), 0);
        repeat (extra) @(negedge Clock);
    endtask

    task automatic check_cmd(input string tag, input int idx, input logic [7:0] op,
                             input logic [31:0] arg, input logic [3:0] n);
        if (idx >= cmdq.size()) begin
            check_val({tag, "_present"}, 0, 1);
        end else begin
            check_val({tag, "_op"},  cmdq[idx].op,  op);
            check_val({tag, "_arg"}, cmdq[idx].arg, arg);
            check_val({tag, "_cnt"}, cmdq[idx].n,   n);
        end
    endtask

    initial begin
        int cb, eb, pb, hold_n, cd_n, w;
        Reset_n = 1'b0;
        CmdReady = 1'b0;
        CurrentData = 8'h00;
        DataAvailable = 1'b0;
        repeat (3) @(negedge Clock);
        check_val("rst_valid", CmdValid, 0);
        check_val("rst_clear", ClearData, 0);
        check_val("rst_error", CmdError, 0);
        check_val("rst_outs", {CmdOp, CmdArg, CmdArgCount, ErrCode}, 0);
        Reset_n = 1'b1;

        // Basic command with immediate acceptance
        CmdReady = 1'b1;
        cb = cmdq.size(); eb = errq.size(); pb = clr_pulses;
        push_str("$R1A\015");
        drain(10);
        check_val("t1_ncmd", cmdq.size() - cb, 1);
        check_cmd("t1", cb, 8'h52, 32'h1A, 4'd2);
        check_val("t1_pulses", clr_pulses - pb, 5);
        check_val("t1_noerr", errq.size() - eb, 0);

        // Backpressure: hold S for 20 cycles with T queued behind it
        CmdReady = 1'b0;
        cb = cmdq.size();
        push_str("$S\015");
        w = 0;
        while (!CmdValid && w < 50) begin
            @(negedge Clock);
            w++;
        end
        check_val("t2_valid", CmdValid, 1);
        push_str("$T\015");
        hold_n = 0; cd_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (CmdValid) hold_n++;
            if (ClearData) cd_n++;
        end
        check_val("t2_held", hold_n, 20);
        check_val("t2_noclr", cd_n, 0);
        check_val("t2_waiting", DataAvailable, 1);
        CmdReady = 1'b1;
        drain(10);
        check_val("t2_ncmd", cmdq.size() - cb, 2);
        check_cmd("t2_s", cb, 8'h53, 32'h0, 4'd0);
        check_cmd("t2_t", cb + 1, 8'h54, 32'h0, 4'd0);

        // Nine digits overflow an 8-digit argument; eight lower-case digits fit
        cb = cmdq.size(); eb = errq.size();
        push_str("$W123456789\015");
        drain(10);
        check_val("t3_nerr", errq.size() - eb, 1);
        if (errq.size() > eb) check_val("t3_code", errq[eb], 2'b11);
        check_val("t3_nocmd", cmdq.size() - cb, 0);
        push_str("$Zdeadbeef\015");
        drain(10);
        check_cmd("t3_max", cb, 8'h5A, 32'hDEADBEEF, 4'd8);

        // Bad opcode, lower-case opcode, resync on '$' inside arguments
        cb = cmdq.size(); eb = errq.size();
        push_str("$7$a$A1$B2\015");
        drain(10);
        check_val("t4_nerr", errq.size() - eb, 3);
        if (errq.size() >= eb + 3) begin
            check_val("t4_code0", errq[eb],     2'b01);
            check_val("t4_code1", errq[eb + 1], 2'b01);
            check_val("t4_code2", errq[eb + 2], 2'b10);
        end
        check_val("t4_ncmd", cmdq.size() - cb, 1);
        check_cmd("t4_b", cb, 8'h42, 32'h2, 4'd1);

        // Inter-byte timeout, then the parser is back in IDLE
        cb = cmdq.size(); eb = errq.size();
        push_str("$A1");
        drain(120);
        check_val("t5_nerr", errq.size() - eb, 1);
        if (errq.size() > eb) check_val("t5_code", errq[eb], 2'b00);
        check_val("t5_delay", err_cyc - last_clr, 100);
        check_val("t5_nocmd", cmdq.size() - cb, 0);
        push_str("$C\015");
        drain(10);
        check_cmd("t5_c", cb, 8'h43, 32'h0, 4'd0);

        // Reset mid-frame discards the partial command
        cb = cmdq.size(); eb = errq.size();
        push_str("$A12");
        drain(4);
        Reset_n = 1'b0;
        repeat (2) @(negedge Clock);
        check_val("t6_rst_outs", {CmdValid, ClearData, CmdError, CmdOp, CmdArg, CmdArgCount}, 0);
        Reset_n = 1'b1;
        push_str("$B\015");
        drain(10);
        check_val("t6_ncmd", cmdq.size() - cb, 1);
        check_cmd("t6_b", cb, 8'h42, 32'h0, 4'd0);
        check_val("t6_noerr", errq.size() - eb, 0);

        check_val("hold_no_pop", hold_clr, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
